// File: rtl/dmx_pkg.sv
// rtl/dmx_pkg.sv - DMX512 shared state type, timing constants and refresh-period lookup
package dmx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_SLOT,
        ST_WAIT
    } dmx_state_t;

    localparam int PERIOD_W = 20;

    function automatic int bit_clks(input int clk_freq);
        return clk_freq / 250_000;
    endfunction

    function automatic int break_clks(input int clk_freq);
        return (clk_freq / 1000) * 176 / 1000;
    endfunction

    function automatic int mab_clks(input int clk_freq);
        return (clk_freq / 1000) * 12 / 1000;
    endfunction

    function automatic int mtbp_clks(input int clk_freq);
        return bit_clks(clk_freq);
    endfunction

    // Break-to-break period in clocks; 0 means free-run.
    function automatic int refresh_clks(input int clk_freq, input logic [1:0] mode);
        case (mode)
            2'd1:    return clk_freq / 40;
            2'd2:    return (clk_freq + 15) / 30;
            2'd3:    return clk_freq / 20;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/dmx_slot_serializer.sv
// rtl/dmx_slot_serializer.sv - one 11-bit DMX slot (start, 8 data LSB first, 2 stop) and the line flop
module dmx_slot_serializer #(
    parameter int BIT_CLKS = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       brk_set,
    input  logic       brk_clr,
    output logic       serial_bit,
    output logic       slot_done
);

    localparam int CW = $clog2(BIT_CLKS + 1);

    logic [CW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    shift;
    logic          active;

    // Combinational so the next slot's start bit can begin on the same edge.
    assign slot_done = active && (bit_cnt == CW'(BIT_CLKS - 1)) && (bit_idx == 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_bit <= 1'b1;
            shift      <= '1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            active     <= 1'b0;
        end else if (brk_set) begin
            serial_bit <= 1'b0;
        end else if (brk_clr) begin
            serial_bit <= 1'b1;
        end else if (load) begin
            serial_bit <= 1'b0;
            shift      <= {2'b11, data};
            bit_cnt    <= '0;
            bit_idx    <= '0;
            active     <= 1'b1;
        end else if (active) begin
            if (bit_cnt == CW'(BIT_CLKS - 1)) begin
                bit_cnt <= '0;
                if (bit_idx == 4'd10) begin
                    active <= 1'b0;
                end else begin
                    serial_bit <= shift[0];
                    shift      <= {1'b1, shift[9:1]};
                    bit_idx    <= bit_idx + 4'd1;
                end
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dmx_tx_engine.sv
// rtl/dmx_tx_engine.sv - DMX512 packet transmitter: break, MAB, slots and refresh pacing
module dmx_tx_engine
    import dmx_pkg::*;
#(
    parameter int         CLK_FREQ        = 20_000_000,
    parameter int         DMX_BUFFER_SIZE = 8,
    parameter logic [7:0] START_CODE      = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [8*DMX_BUFFER_SIZE-1:0] DMX_Data,
    input  logic [9:0]                   N_Of_Bytes,
    input  logic                         TX_EN,
    input  logic [1:0]                   FREQ_MODE,
    output logic                         DMX_Output_Signal,
    output logic                         DE,
    output logic                         Busy,
    output logic                         Packet_Done
);

    localparam int BIT_CLKS   = bit_clks(CLK_FREQ);
    localparam int BREAK_CLKS = break_clks(CLK_FREQ);
    localparam int MAB_CLKS   = mab_clks(CLK_FREQ);
    localparam int MTBP_CLKS  = mtbp_clks(CLK_FREQ);
    localparam int TW         = $clog2(BREAK_CLKS + 1);
    localparam int SW         = $clog2(DMX_BUFFER_SIZE + 1);

    dmx_state_t          state;
    logic [TW-1:0]       tcnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [SW-1:0]       slot_idx;
    logic [SW-1:0]       n_lat;
    logic [1:0]          mode_lat;
    logic                de_q, busy_q, done_q;

    logic          break_end, mab_end, period_ok, wait_end, last_slot;
    logic          brk_set, ser_load, slot_done;
    logic [7:0]    ser_byte;
    logic [SW-1:0] n_clamped;

    assign break_end = (state == ST_BREAK) && (tcnt == TW'(BREAK_CLKS - 1));
    assign mab_end   = (state == ST_MAB) && (tcnt == TW'(MAB_CLKS - 1));
    assign period_ok = (mode_lat == 2'd0) ||
                       (int'({12'd0, period_cnt}) >= refresh_clks(CLK_FREQ, mode_lat) - 1);
    assign wait_end  = (state == ST_WAIT) && (tcnt == TW'(MTBP_CLKS - 1)) && period_ok;
    assign last_slot = (slot_idx == n_lat);
    assign brk_set   = ((state == ST_IDLE) || wait_end) && TX_EN;
    assign ser_load  = mab_end || ((state == ST_SLOT) && slot_done && !last_slot);
    assign n_clamped = (N_Of_Bytes > 10'(DMX_BUFFER_SIZE)) ? SW'(DMX_BUFFER_SIZE) : SW'(N_Of_Bytes);

    // Slot k+1 carries byte k, read live when its start bit begins.
    always_comb begin
        ser_byte = START_CODE;
        if (state == ST_SLOT) begin
            ser_byte = 8'h00;
            for (int i = 0; i < DMX_BUFFER_SIZE; i++) begin
                if (slot_idx == SW'(i)) ser_byte = DMX_Data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            period_cnt <= '0;
            slot_idx   <= '0;
            n_lat      <= '0;
            mode_lat   <= 2'd0;
            de_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_W'(1);
            if (brk_set) begin
                state      <= ST_BREAK;
                tcnt       <= '0;
                period_cnt <= '0;
                n_lat      <= n_clamped;
                mode_lat   <= FREQ_MODE;
                de_q       <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_BREAK: begin
                        tcnt <= break_end ? '0 : tcnt + TW'(1);
                        if (break_end) state <= ST_MAB;
                    end
                    ST_MAB: begin
                        tcnt <= mab_end ? '0 : tcnt + TW'(1);
                        if (mab_end) begin
                            state    <= ST_SLOT;
                            slot_idx <= '0;
                        end
                    end
                    ST_SLOT: begin
                        if (slot_done) begin
                            if (last_slot) begin
                                state  <= ST_WAIT;
                                tcnt   <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                slot_idx <= slot_idx + SW'(1);
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wait_end) begin
                            state <= ST_IDLE;
                            de_q  <= 1'b0;
                        end else if (tcnt != TW'(MTBP_CLKS - 1)) begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    dmx_slot_serializer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .data       (ser_byte),
        .brk_set    (brk_set),
        .brk_clr    (break_end),
        .serial_bit (DMX_Output_Signal),
        .slot_done  (slot_done)
    );

    assign DE          = de_q;
    assign Busy        = busy_q;
    assign Packet_Done = done_q;

endmodule
